// File: rtl/timer_unit.sv
// ---------------------------------------------------------------------------
// timer_unit
//   Bus-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
//
//   Register map (word offset on Addr):
//     0 CTRL   : [0] Enable, [2:1] Mode (01 = auto-reload, else one-shot),
//                [3] IM interrupt mask; bits 31:4 read as 0
//     1 PRESET : reload value, read/write
//     2 COUNT  : current count, read-only
//     3        : reserved, reads 0
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     Addr   word offset
//     We     write strobe
//     BE     byte enables, BE[i] covers WD[8i+7:8i]
//     WD     write data
//     RD     combinational read data
//     IRQ    registered interrupt request (irq_flag AND IM)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | stopped; COUNT held; leaves when Enable=1
//   LOAD   | COUNT <= PRESET
//   CNT    | decrementing; Enable=0 pauses back to IDLE
//   INT    | terminal count reached; reload (mode 01) or stop (one-shot)
// ---------------------------------------------------------------------------
module timer_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic        enable;
  logic [1:0]  mode;
  logic        wr_ctrl;
  logic        wr_preset;

  assign enable    = ctrl_q[0];
  assign mode      = ctrl_q[2:1];
  assign wr_ctrl   = We && (Addr == ADDR_CTRL);
  assign wr_preset = We && (Addr == ADDR_PRESET);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // Any CTRL write acknowledges a pending one-shot interrupt.
    if (wr_ctrl) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers both COUNT=1 and PRESET=0; COUNT never goes below 0.
          count_d    = 32'd0;
          state_d    = S_INT;
          irq_flag_d = 1'b1;
        end
      end
      S_INT: begin
        if (mode == 2'b01) begin
          state_d    = S_LOAD;
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase

    // Bus write applied last so it overrides the one-shot Enable clear.
    if (wr_ctrl && BE[0]) begin
      ctrl_d = WD[3:0];
    end

    if (wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) begin
          preset_d[8*i +: 8] = WD[8*i +: 8];
        end
      end
    end
  end

  // IRQ is taken from a flop so it is glitch-free.
  assign irq_d = irq_flag_d & ctrl_d[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   RD = {28'd0, ctrl_q};
      ADDR_PRESET: RD = preset_q;
      ADDR_COUNT:  RD = count_q;
      default:     RD = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_timer_unit
//   Directed bench for timer_unit. Stimulus pushes expected RD/IRQ values into
//   a queue; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_timer_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  timer_unit dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .We    (We),
    .BE    (BE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_irq;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    chk_t        c;
    logic [31:0] actual;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        actual = c.is_irq ? {31'd0, IRQ} : RD;
        n_checks++;
        if (actual !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, actual, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    Addr = a;
    BE   = be;
    WD   = d;
    We   = 1'b1;
    tick();
    We   = 1'b0;
    BE   = 4'd0;
  endtask

  task automatic chk(input string nm, input logic [1:0] a,
                     input logic [31:0] exp_rd, input logic exp_irq);
    Addr = a;
    q.push_back('{nm, 1'b0, exp_rd});
    q.push_back('{{nm, "_irq"}, 1'b1, {31'd0, exp_irq}});
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Addr  = 2'd0;
    We    = 1'b0;
    BE    = 4'd0;
    WD    = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_ctrl",   2'd0, 32'd0, 1'b0);
    chk("rst_preset", 2'd1, 32'd0, 1'b0);
    chk("rst_count",  2'd2, 32'd0, 1'b0);
    chk("rst_rsvd",   2'd3, 32'd0, 1'b0);

    // One-shot, PRESET=3, CTRL=0x9 at E0
    do_reset();
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'hF, 32'h9);                  // E0
    tick(); tick();                         // E2
    chk("os_cnt3", 2'd2, 32'd3, 1'b0);
    tick(); chk("os_cnt2", 2'd2, 32'd2, 1'b0);
    tick(); chk("os_cnt1", 2'd2, 32'd1, 1'b0);
    tick(); chk("os_cnt0", 2'd2, 32'd0, 1'b1);   // E5
    tick(); chk("os_ctrl", 2'd0, 32'h8, 1'b1);   // Enable cleared
    tick(); chk("os_hold", 2'd2, 32'd0, 1'b1);
    wr(2'd0, 4'hF, 32'h8);
    chk("os_ack", 2'd0, 32'h8, 1'b0);

    // CTRL write coinciding with the one-shot Enable clear wins
    wr(2'd1, 4'hF, 32'd1);
    wr(2'd0, 4'hF, 32'h9);                  // E0
    tick(); tick(); chk("pri_cnt1", 2'd2, 32'd1, 1'b0);
    tick(); chk("pri_int", 2'd2, 32'd0, 1'b1);   // E3
    wr(2'd0, 4'hF, 32'h9);                  // E4 = INT cycle
    chk("pri_ctrl", 2'd0, 32'h9, 1'b0);
    tick(); chk("pri_load", 2'd2, 32'd0, 1'b0);
    tick(); chk("pri_cnt1b", 2'd2, 32'd1, 1'b0);
    tick(); chk("pri_int2", 2'd2, 32'd0, 1'b1);

    // Auto-reload, PRESET=2, CTRL=0xB
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'hB);                  // E0
    tick(); tick(); chk("ar_c2a", 2'd2, 32'd2, 1'b0);
    tick(); chk("ar_c1a", 2'd2, 32'd1, 1'b0);
    tick(); chk("ar_c0a", 2'd2, 32'd0, 1'b1);
    tick(); chk("ar_lda", 2'd2, 32'd0, 1'b0);
    tick(); chk("ar_c2b", 2'd2, 32'd2, 1'b0);
    tick(); chk("ar_c1b", 2'd2, 32'd1, 1'b0);
    tick(); chk("ar_c0b", 2'd2, 32'd0, 1'b1);
    tick(); chk("ar_ldb", 2'd2, 32'd0, 1'b0);
    tick(); chk("ar_ctrl", 2'd0, 32'hB, 1'b0);

    // Pause / resume / mask / PRESET write during CNT
    do_reset();
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h1);                  // E0, IM=0
    tick(); tick(); tick(); tick();         // E4
    chk("pa_c3", 2'd2, 32'd3, 1'b0);
    wr(2'd0, 4'hF, 32'h0);                  // E5: still decrements here
    chk("pa_c2", 2'd2, 32'd2, 1'b0);
    tick(); chk("pa_frz1", 2'd2, 32'd2, 1'b0);
    tick(); chk("pa_frz2", 2'd2, 32'd2, 1'b0);
    wr(2'd0, 4'hF, 32'h1);                  // E8
    chk("pa_idle", 2'd2, 32'd2, 1'b0);
    tick(); chk("pa_load", 2'd2, 32'd2, 1'b0);   // E9 LOAD state
    tick(); chk("pa_reld", 2'd2, 32'd5, 1'b0);   // E10 reloaded
    wr(2'd1, 4'hF, 32'd1);                  // E11, PRESET write in CNT
    chk("pa_c4", 2'd2, 32'd4, 1'b0);
    tick(); tick(); tick();
    chk("pa_c1", 2'd2, 32'd1, 1'b0);        // E14
    tick(); chk("pa_mask", 2'd2, 32'd0, 1'b0);   // E15, flag set but IM=0
    tick(); chk("pa_ctrl", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 4'hF, 32'h9);                  // E0
    tick(); tick(); chk("pa_newp", 2'd2, 32'd1, 1'b0);
    tick(); chk("pa_irq", 2'd2, 32'd0, 1'b1);

    // Byte enables and read-only offsets
    do_reset();
    wr(2'd1, 4'b0101, 32'hAABBCCDD);
    chk("be_preset", 2'd1, 32'h00BB00DD, 1'b0);
    wr(2'd2, 4'hF, 32'hFFFFFFFF);
    chk("ro_count", 2'd2, 32'd0, 1'b0);
    wr(2'd3, 4'hF, 32'hFFFFFFFF);
    chk("ro_rsvd", 2'd3, 32'd0, 1'b0);
    wr(2'd0, 4'b1110, 32'hFFFFFFFF);
    chk("be_ctrl0", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 4'hF, 32'hFFFFFFF6);
    chk("ctrl_upper", 2'd0, 32'h6, 1'b0);
    chk("be_keep", 2'd1, 32'h00BB00DD, 1'b0);

    // PRESET=0 one-shot
    do_reset();
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'hF, 32'h9);                  // E0
    tick(); tick(); chk("z_e2", 2'd2, 32'd0, 1'b0);
    tick(); chk("z_e3", 2'd2, 32'd0, 1'b1);

    // Reset mid-count, with a simultaneous PRESET write
    do_reset();
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'hF, 32'h9);                  // E0
    tick(); tick(); tick(); tick();
    chk("mr_c8", 2'd2, 32'd8, 1'b0);
    reset = 1'b1;
    Addr  = 2'd1;
    BE    = 4'hF;
    WD    = 32'h55;
    We    = 1'b1;
    tick();
    reset = 1'b0;
    We    = 1'b0;
    BE    = 4'd0;
    chk("mr_preset", 2'd1, 32'd0, 1'b0);
    chk("mr_count",  2'd2, 32'd0, 1'b0);
    chk("mr_ctrl",   2'd0, 32'd0, 1'b0);
    tick(); tick();
    chk("mr_stay",   2'd2, 32'd0, 1'b0);

    tick();
    tick();
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_checks: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  2  word offset (processor address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- We  input  1  write strobe from processor bus.
- BE  input  4  byte enables for the write; BE[i] covers WD[8i+7:8i].
- WD  input  32  write data.
- RD  output  32  read data.
- IRQ  output  1  interrupt request to one processor HWInt line.
REQ-002 The block SHALL have the following parameters:
- None; all register widths fixed at 32 bits.

Function
REQ-003 CTRL SHALL hold Enable (bit 0), Mode (bits 2:1) and IM, the interrupt mask (bit 3); CTRL bits 31:4 SHALL read 0 and ignore writes.
REQ-004 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be a 32-bit read-only register, and writes to it or to offset 3 SHALL be ignored.
REQ-005 A write SHALL update only the bytes whose BE bit is 1, at the clock edge where We=1.
REQ-006 RD SHALL be combinational from Addr and current register values: CTRL zero-extended, PRESET, COUNT, or 0 for offset 3.
REQ-007 Control SHALL be a 4-state FSM (IDLE, LOAD, CNT, INT) with an internal irq_flag.
REQ-008 IDLE: if Enable=1, next state SHALL be LOAD; otherwise stay in IDLE with COUNT held.
REQ-009 LOAD: COUNT SHALL be set to PRESET and the next state SHALL be CNT.
REQ-010 CNT with Enable=0: next state SHALL be IDLE and COUNT SHALL be held (pause).
REQ-011 CNT with Enable=1 and COUNT>1: COUNT SHALL be decremented by 1.
REQ-012 CNT with Enable=1 and COUNT=1: COUNT SHALL become 0, the next state SHALL be INT, and irq_flag SHALL be set.
REQ-013 CNT with Enable=1 and COUNT=0 (PRESET=0 case): the next state SHALL be INT and irq_flag SHALL be set.
REQ-014 INT, Mode=00/10/11 (one-shot): Enable SHALL be cleared, the next state SHALL be IDLE, and irq_flag SHALL stay 1 until any write to CTRL.
REQ-015 INT, Mode=01 (auto-reload): the next state SHALL be LOAD and irq_flag SHALL clear, giving a one-cycle IRQ pulse per period.
REQ-016 IRQ SHALL equal irq_flag AND IM, registered-derived and glitch-free.
REQ-017 A CTRL write in the same cycle as the INT-state Enable clear SHALL take priority, and the written Enable value SHALL persist.
REQ-018 A PRESET write while in CNT SHALL NOT alter COUNT; it SHALL take effect at the next LOAD.
REQ-019 Timing: with Enable set by the write at edge E0 and PRESET=N≥1, IRQ SHALL rise after edge E0+N+2; for N=0, after edge E0+3.
REQ-020 Auto-reload period SHALL be N+2 cycles for N≥1.
REQ-021 There SHALL be no COUNT wrap-around: COUNT never decrements below 0.

Reset
REQ-022 On reset=1 at a clock edge: CTRL, PRESET, COUNT and irq_flag SHALL be 0, the state SHALL be IDLE, and IRQ SHALL be 0.
REQ-023 Reset mid-count SHALL abort the operation immediately.
REQ-024 Reset SHALL take priority over a simultaneous bus write.

Verification
REQ-025 Reset, then read offsets 0/1/2/3 -> RD=0 for each; IRQ=0.
REQ-026 One-shot: PRESET=3, then CTRL=0x9 (Enable, Mode 00, IM) at E0 -> COUNT 3,2,1,0 at E2..E5; IRQ=1 from E5 on; CTRL reads 0x8; a write of CTRL=0x8 -> IRQ=0 next cycle.
REQ-027 Auto-reload: PRESET=2, CTRL=0xB -> IRQ one-cycle pulses every 4 cycles; COUNT sequence 2,1,0,0(LOAD),2,...
REQ-028 Pause/mask: mid-count write CTRL=0x0 -> COUNT frozen; CTRL=0x1 -> resumes from frozen value via LOAD (reloads PRESET); IM=0 -> IRQ stays 0 while irq_flag is set.
REQ-029 Byte enables/read-only: write PRESET=0xAABBCCDD with BE=0101 over 0 -> PRESET=0x00BB00DD; write to COUNT -> unchanged.
REQ-030 PRESET=0 one-shot -> IRQ after E0+3; reset asserted during CNT -> all registers 0 next edge.
